// File: rtl/uart_port_responder_if.sv
// ----------------------------------------------------------------------------
// uart_port_responder_if
// Groups the CPU-side UART request/ack signals, the board serial pins and the
// receiver status flags into one bundle.
//   slave  : the responder (device side)
//   master : the CPU / board side that drives requests and the serial input
// Signals:
//   uartReadReq    CPU -> dev  request one received byte, held until ack
//   uartReadAck    dev -> CPU  one-cycle pulse, uartReadData valid
//   uartReadData   dev -> CPU  returned byte, holds until the next ack
//   uartWriteReq   CPU -> dev  request transmit of uartWriteData
//   uartWriteData  CPU -> dev  byte to transmit
//   uartWriteReady dev -> CPU  transmitter idle
//   uartRx         pin -> dev  serial input, idle high
//   uartTx         dev -> pin  serial output, idle high
//   rxOverflow     dev -> CPU  sticky, received byte dropped on full FIFO
//   rxFrameError   dev -> CPU  one-cycle pulse, bad stop bit
// ----------------------------------------------------------------------------
interface uart_port_responder_if;
   logic       uartReadReq;
   logic       uartReadAck;
   logic [7:0] uartReadData;
   logic       uartWriteReq;
   logic [7:0] uartWriteData;
   logic       uartWriteReady;
   logic       uartRx;
   logic       uartTx;
   logic       rxOverflow;
   logic       rxFrameError;

   modport slave (
      input  uartReadReq, uartWriteReq, uartWriteData, uartRx,
      output uartReadAck, uartReadData, uartWriteReady, uartTx,
             rxOverflow, rxFrameError
   );

   modport master (
      output uartReadReq, uartWriteReq, uartWriteData, uartRx,
      input  uartReadAck, uartReadData, uartWriteReady, uartTx,
             rxOverflow, rxFrameError
   );
endinterface

// File: rtl/uart_port_responder.sv
// ----------------------------------------------------------------------------
// uart_port_responder
// Device-side end of the CPU UART request/ack interface. An 8N1 receiver
// feeds an RX FIFO that answers read requests; a single-byte 8N1 transmitter
// accepts write requests.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    uart_port_responder_if.slave (handshakes, serial pins, flags)
// Parameters:
//   CLKS_PER_BIT   clk cycles per serial bit (>= 4)
//   RX_FIFO_DEPTH  RX FIFO entries (power of two, >= 2)
// Configuration macro:
//   UART_LOOPBACK_EN  when defined the receiver listens to the internal TX
//                     stream, uartRx is ignored and uartTx is held high.
// ----------------------------------------------------------------------------
module uart_port_responder #(
   parameter int CLKS_PER_BIT  = 434,
   parameter int RX_FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   uart_port_responder_if.slave  bus
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(RX_FIFO_DEPTH);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

   // ------------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t       tx_state_q, tx_state_d;
   logic [TW-1:0]   tx_timer_q, tx_timer_d;
   logic [2:0]      tx_idx_q, tx_idx_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            tx_q, tx_d;
   logic            tx_ready;

   assign tx_ready = (tx_state_q == TX_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         tx_timer_q <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_timer_q <= tx_timer_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_timer_d = tx_timer_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_d       = 1'b1;
      unique case (tx_state_q)
         TX_IDLE: begin
            if (bus.uartWriteReq) begin
               tx_shift_d = bus.uartWriteData;
               tx_timer_d = '0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_timer_q == BIT_LAST) begin
               tx_timer_d = '0;
               tx_idx_d   = '0;
               tx_state_d = TX_DATA;
            end else begin
               tx_timer_d = tx_timer_q + TW'(1);
            end
         end
         TX_DATA: begin
            if (tx_timer_q == BIT_LAST) begin
               tx_timer_d = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_idx_q == 3'd7) begin
                  tx_state_d = TX_STOP;
               end else begin
                  tx_idx_d = tx_idx_q + 3'd1;
               end
            end else begin
               tx_timer_d = tx_timer_q + TW'(1);
            end
         end
         TX_STOP: begin
            if (tx_timer_q == BIT_LAST) begin
               tx_timer_d = '0;
               tx_state_d = TX_IDLE;
            end else begin
               tx_timer_d = tx_timer_q + TW'(1);
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      // Line level is registered from the next state so the pin never glitches.
      case (tx_state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = tx_shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------------
   // Receiver input selection and synchronizer
   // ------------------------------------------------------------------------
   logic rx_src;
`ifdef UART_LOOPBACK_EN
   assign rx_src     = tx_q;
   assign bus.uartTx = 1'b1;
`else
   assign rx_src     = bus.uartRx;
   assign bus.uartTx = tx_q;
`endif

   logic rx_meta_q, rx_sync_q, rx_prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_src;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // ------------------------------------------------------------------------
   // Receiver FSM
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t       rx_state_q, rx_state_d;
   logic [TW-1:0]   rx_timer_q, rx_timer_d;
   logic [2:0]      rx_idx_q, rx_idx_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            rx_push;
   logic            rx_frame_err;
   logic            frame_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state_q  <= RX_IDLE;
         rx_timer_q  <= '0;
         rx_idx_q    <= '0;
         rx_shift_q  <= '0;
         frame_err_q <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         rx_timer_q  <= rx_timer_d;
         rx_idx_q    <= rx_idx_d;
         rx_shift_q  <= rx_shift_d;
         frame_err_q <= rx_frame_err;
      end
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_timer_d   = rx_timer_q;
      rx_idx_d     = rx_idx_q;
      rx_shift_d   = rx_shift_q;
      rx_push      = 1'b0;
      rx_frame_err = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_timer_d = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            // Half-bit re-check rejects short glitches and centres later samples.
            if (rx_timer_q == HALF_LAST) begin
               rx_timer_d = '0;
               rx_idx_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_timer_d = rx_timer_q + TW'(1);
            end
         end
         RX_DATA: begin
            if (rx_timer_q == BIT_LAST) begin
               rx_timer_d = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_idx_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_idx_d = rx_idx_q + 3'd1;
               end
            end else begin
               rx_timer_d = rx_timer_q + TW'(1);
            end
         end
         RX_STOP: begin
            // Back to idle at mid stop bit so the next start edge is never missed.
            if (rx_timer_q == BIT_LAST) begin
               rx_timer_d   = '0;
               rx_state_d   = RX_IDLE;
               rx_push      = rx_sync_q;
               rx_frame_err = !rx_sync_q;
            end else begin
               rx_timer_d = rx_timer_q + TW'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // RX FIFO and read responder
   // ------------------------------------------------------------------------
   logic [7:0]  fifo_mem [RX_FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        fifo_empty, fifo_full;
   logic        pop, push_ok;
   logic        armed_q;
   logic        ack_q;
   logic [7:0]  read_data_q;
   logic        overflow_q;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = armed_q && bus.uartReadReq && !fifo_empty;
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign push_ok    = rx_push && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= rx_shift_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         armed_q     <= 1'b1;
         ack_q       <= 1'b0;
         read_data_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         ack_q <= pop;
         if (pop) begin
            read_data_q <= fifo_mem[rd_ptr_q[AW-1:0]];
            rd_ptr_q    <= rd_ptr_q + (AW+1)'(1);
         end
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         end
         if (rx_push && !push_ok) begin
            overflow_q <= 1'b1;
         end
         // One ack per request: re-arm only once the request has been dropped.
         if (!bus.uartReadReq) begin
            armed_q <= 1'b1;
         end else if (pop) begin
            armed_q <= 1'b0;
         end
      end
   end

   assign bus.uartReadAck    = ack_q;
   assign bus.uartReadData   = read_data_q;
   assign bus.uartWriteReady = tx_ready;
   assign bus.rxOverflow     = overflow_q;
   assign bus.rxFrameError   = frame_err_q;

endmodule

// File: tb/tb_uart_port_responder.sv
module tb_uart_port_responder;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_port_responder_if bus();

   uart_port_responder #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int ack_count = 0;
   int fe_count  = 0;
   logic [7:0] last_ack_data = '0;

   always @(negedge clk) begin
      if (bus.uartReadAck === 1'b1) begin
         ack_count++;
         last_ack_data = bus.uartReadData;
      end
      if (bus.rxFrameError === 1'b1) fe_count++;
   end

   typedef struct {
      logic [7:0] data;
      logic       stop_bit;
      logic       exp_fe;
      logic       exp_ack;
      logic [7:0] exp_data;
   } rx_vec_t;

   typedef struct {
      logic [7:0] data;
      logic [9:0] exp_frame;
   } tx_vec_t;

   rx_vec_t    rx_tab[6];
   tx_vec_t    tx_tab[4];
   logic       got;
   logic [7:0] rd;
   logic [7:0] model_q[$];
   int         a0, f0, tx_low;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_serial(input logic [7:0] b, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         bus.uartRx = fr[i];
         repeat (CPB) tick();
      end
      bus.uartRx = 1'b1;
      repeat (2) tick();
   endtask

   task automatic do_read(input int budget, output logic g, output logic [7:0] d);
      g = 1'b0;
      d = '0;
      bus.uartReadReq = 1'b1;
      for (int i = 0; i < budget && !g; i++) begin
         tick();
         if (bus.uartReadAck === 1'b1) begin
            g = 1'b1;
            d = bus.uartReadData;
         end
      end
      bus.uartReadReq = 1'b0;
      tick();
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      while (bus.uartWriteReady !== 1'b1 && w < 200) begin
         tick();
         w++;
      end
      check("tx_ready_wait", 32'(bus.uartWriteReady), 32'd1);
   endtask

   task automatic tx_frame_check(input logic [7:0] b, input logic [9:0] exp_frame);
      wait_ready();
      bus.uartWriteData = b;
      bus.uartWriteReq  = 1'b1;
      tick();
      bus.uartWriteReq  = 1'b0;
      repeat (4) tick();                 // middle of start bit
      for (int k = 0; k < 10; k++) begin
         check("tx_bit", 32'(bus.uartTx), 32'(exp_frame[k]));
         check("tx_busy", 32'(bus.uartWriteReady), 32'd0);
         if (k == 2) begin
            // A request while busy must be ignored, not queued.
            bus.uartWriteData = ~b;
            bus.uartWriteReq  = 1'b1;
         end
         if (k < 9) repeat (CPB) tick();
         bus.uartWriteReq = 1'b0;
      end
      repeat (3) tick();                 // last busy cycle of the frame
      check("tx_ready_last_busy", 32'(bus.uartWriteReady), 32'd0);
      tick();
      check("tx_ready_after_frame", 32'(bus.uartWriteReady), 32'd1);
      check("tx_idle_line", 32'(bus.uartTx), 32'd1);
   endtask

   initial begin
      bus.uartReadReq   = 1'b0;
      bus.uartWriteReq  = 1'b0;
      bus.uartWriteData = '0;
      bus.uartRx        = 1'b1;
      reset             = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack",   32'(bus.uartReadAck),    32'd0);
      check("rst_data",  32'(bus.uartReadData),   32'd0);
      check("rst_ready", 32'(bus.uartWriteReady), 32'd1);
      check("rst_tx",    32'(bus.uartTx),         32'd1);
      check("rst_ovf",   32'(bus.rxOverflow),     32'd0);
      check("rst_fe",    32'(bus.rxFrameError),   32'd0);
      reset = 1'b0;
      repeat (2) tick();

`ifdef UART_LOOPBACK_EN
      wait_ready();
      bus.uartWriteData = 8'h5A;
      bus.uartWriteReq  = 1'b1;
      tick();
      bus.uartWriteReq  = 1'b0;
      tx_low = 0;
      for (int i = 0; i < 85; i++) begin
         if (bus.uartTx !== 1'b1) tx_low++;
         tick();
      end
      check("lb_tx_held_high", 32'(tx_low), 32'd0);
      do_read(150, got, rd);
      check("lb_ack", 32'(got), 32'd1);
      check("lb_data", 32'(rd), 32'h5A);
      do_read(40, got, rd);
      check("lb_no_extra", 32'(got), 32'd0);
`else
      // ---------------- TX table ----------------
      tx_tab[0] = '{8'hA5, 10'b1101001010};
      tx_tab[1] = '{8'h00, {1'b1, 8'h00, 1'b0}};
      tx_tab[2] = '{8'hFF, {1'b1, 8'hFF, 1'b0}};
      tx_tab[3] = '{8'h5A, {1'b1, 8'h5A, 1'b0}};
      for (int i = 0; i < 4; i++) begin
         tx_frame_check(tx_tab[i].data, tx_tab[i].exp_frame);
         $display("tx vector %0d data=0x%02h done", i, tx_tab[i].data);
      end

      // ---------------- RX table ----------------
      rx_tab[0] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C};
      rx_tab[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
      rx_tab[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF};
      rx_tab[3] = '{8'h77, 1'b0, 1'b1, 1'b0, 8'h00};
      rx_tab[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80};
      rx_tab[5] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5};
      for (int i = 0; i < 6; i++) begin
         f0 = fe_count;
         send_serial(rx_tab[i].data, rx_tab[i].stop_bit);
         tick();
         check("rx_frame_err_pulses", 32'(fe_count - f0), 32'(rx_tab[i].exp_fe));
         do_read(40, got, rd);
         check("rx_ack", 32'(got), 32'(rx_tab[i].exp_ack));
         if (rx_tab[i].exp_ack) check("rx_data", 32'(rd), 32'(rx_tab[i].exp_data));
         $display("rx vector %0d data=0x%02h stop=%0b ack=%0b got=0x%02h",
                  i, rx_tab[i].data, rx_tab[i].stop_bit, got, rd);
      end

      // ---------------- held request: one ack only ----------------
      send_serial(8'h3C, 1'b1);
      a0 = ack_count;
      bus.uartReadReq = 1'b1;
      for (int i = 0; i < 40 && ack_count == a0; i++) tick();
      repeat (20) tick();
      bus.uartReadReq = 1'b0;
      tick();
      check("held_req_ack_count", 32'(ack_count - a0), 32'd1);
      check("held_req_data", 32'(last_ack_data), 32'h3C);
      $display("held request: acks=%0d data=0x%02h", ack_count - a0, last_ack_data);

      // ---------------- glitch rejection ----------------
      f0 = fe_count;
      bus.uartRx = 1'b0;
      repeat (3) tick();
      bus.uartRx = 1'b1;
      repeat (100) tick();
      do_read(40, got, rd);
      check("glitch_no_byte", 32'(got), 32'd0);
      check("glitch_no_fe", 32'(fe_count - f0), 32'd0);
      $display("glitch: ack=%0b", got);

      // ---------------- randomized RX traffic vs queue model ----------------
      for (int r = 0; r < 8; r++) begin
         int n, nr;
         logic [7:0] b;
         n = $urandom_range(1, DEPTH - model_q.size());
         for (int j = 0; j < n; j++) begin
            b = 8'($urandom_range(0, 255));
            send_serial(b, 1'b1);
            model_q.push_back(b);
         end
         nr = $urandom_range(0, model_q.size());
         for (int j = 0; j < nr; j++) begin
            do_read(40, got, rd);
            check("rand_ack", 32'(got), 32'd1);
            check("rand_data", 32'(rd), 32'(model_q[0]));
            $display("rand round %0d read got=0x%02h exp=0x%02h", r, rd, model_q[0]);
            void'(model_q.pop_front());
         end
      end
      while (model_q.size() > 0) begin
         do_read(40, got, rd);
         check("drain_data", 32'(rd), 32'(model_q[0]));
         $display("drain read got=0x%02h exp=0x%02h", rd, model_q[0]);
         void'(model_q.pop_front());
      end
      do_read(40, got, rd);
      check("drain_empty", 32'(got), 32'd0);
      check("no_overflow_yet", 32'(bus.rxOverflow), 32'd0);
      for (int j = 0; j < 2; j++) begin
         logic [7:0] b;
         b = 8'($urandom_range(0, 255));
         tx_frame_check(b, {1'b1, b, 1'b0});
         $display("rand tx data=0x%02h done", b);
      end

      // ---------------- overflow ----------------
      for (int j = 1; j <= 5; j++) send_serial(8'(j), 1'b1);
      check("overflow_set", 32'(bus.rxOverflow), 32'd1);
      for (int j = 1; j <= 4; j++) begin
         do_read(40, got, rd);
         check("ovf_read_ack", 32'(got), 32'd1);
         check("ovf_read_data", 32'(rd), 32'(j));
         $display("overflow read %0d got=0x%02h", j, rd);
      end
      do_read(40, got, rd);
      check("ovf_fifth_no_ack", 32'(got), 32'd0);
      check("overflow_sticky", 32'(bus.rxOverflow), 32'd1);

      // ---------------- reset mid TX frame ----------------
      send_serial(8'h42, 1'b1);
      wait_ready();
      bus.uartWriteData = 8'hC3;
      bus.uartWriteReq  = 1'b1;
      tick();
      bus.uartWriteReq  = 1'b0;
      repeat (30) tick();
      #2;
      reset = 1'b1;
      #1;
      check("midrst_tx",    32'(bus.uartTx),         32'd1);
      check("midrst_ready", 32'(bus.uartWriteReady), 32'd1);
      check("midrst_ovf",   32'(bus.rxOverflow),     32'd0);
      check("midrst_fe",    32'(bus.rxFrameError),   32'd0);
      check("midrst_ack",   32'(bus.uartReadAck),    32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      do_read(40, got, rd);
      check("midrst_fifo_empty", 32'(got), 32'd0);
      $display("reset mid frame: tx=%0b ready=%0b fifo_ack=%0b",
               bus.uartTx, bus.uartWriteReady, got);
      tx_frame_check(8'h96, {1'b1, 8'h96, 1'b0});
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
